// File: rtl/hashmap_port_arbiter.sv
// Shares one hashmap (write port, combinational read port, clear) among NUM_REQ requesters.
// Latency: grant and hashmap write/read in the request cycle; lookup response one cycle later.
// Backpressure: combinational one-hot req_ready, round-robin; a clear or reset stalls every requester.
module hashmap_port_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int KEY_WIDTH   = 4,
  parameter int VALUE_WIDTH = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_hit,
  output logic [VALUE_WIDTH-1:0]         rsp_value,
  input  logic                           clear_req,
  output logic                           clear_done,
  output logic [CNT_WIDTH-1:0]           hit_count,
  output logic [CNT_WIDTH-1:0]           miss_count,
  output logic [KEY_WIDTH-1:0]           hm_write_key,
  output logic [VALUE_WIDTH-1:0]         hm_write_value,
  output logic                           hm_write_request,
  output logic [KEY_WIDTH-1:0]           hm_read_key,
  input  logic [VALUE_WIDTH-1:0]         hm_read_value,
  input  logic                           hm_read_response,
  output logic                           hm_clear_cache
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0]        LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [KEY_WIDTH-1:0]   wr_key_q, wr_key_d;
  logic [VALUE_WIDTH-1:0] wr_val_q, wr_val_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic                   rsp_hit_q, rsp_hit_d;
  logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
  logic                   clear_done_q, clear_done_d;
  logic [CNT_WIDTH-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;

  logic                   gnt_found;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_write;
  logic [KEY_WIDTH-1:0]   gnt_key;
  logic [VALUE_WIDTH-1:0] gnt_value;
  logic [KEY_WIDTH-1:0]   ptr_key;
  logic                   grant_en;
  logic                   wr_go;
  logic                   rd_go;

  // Round-robin pick: first valid at or above rr_ptr, otherwise first valid below it (wrap).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (PW'(i) >= rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (PW'(i) < rr_ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
  end

  // Select the granted requester's operation, and the rr_ptr requester's key for idle reads.
  always_comb begin
    gnt_write = 1'b0;
    gnt_key   = '0;
    gnt_value = '0;
    ptr_key   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt_write = req_write[i];
        gnt_key   = req_key[i*KEY_WIDTH +: KEY_WIDTH];
        gnt_value = req_value[i*VALUE_WIDTH +: VALUE_WIDTH];
      end
      if (rr_ptr_q == PW'(i)) begin
        ptr_key = req_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  // Clear and reset both veto the grant; a clear never overlaps a hashmap write.
  always_comb begin
    grant_en         = gnt_found && !clear_req && !rst;
    wr_go            = grant_en && gnt_write;
    rd_go            = grant_en && !gnt_write;
    req_ready        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_en && (gnt_idx == PW'(i));
    end
    hm_clear_cache   = clear_req && !rst;
    hm_write_request = wr_go;
    hm_write_key     = wr_go ? gnt_key   : wr_key_q;
    hm_write_value   = wr_go ? gnt_value : wr_val_q;
    hm_read_key      = rd_go ? gnt_key   : ptr_key;
  end

  // Next state: pointer advance, held write data, lookup response and saturating statistics.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_en) begin
      rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
    end
    wr_key_d     = wr_go ? gnt_key   : wr_key_q;
    wr_val_d     = wr_go ? gnt_value : wr_val_q;
    rsp_valid_d  = rd_go ? req_ready : '0;
    rsp_hit_d    = rd_go && hm_read_response;
    rsp_value_d  = rd_go ? hm_read_value : rsp_value_q;
    clear_done_d = clear_req;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (rd_go) begin
      if (hm_read_response) begin
        if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      wr_key_q     <= '0;
      wr_val_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_value_q  <= '0;
      clear_done_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_key_q     <= wr_key_d;
      wr_val_q     <= wr_val_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_value_q  <= rsp_value_d;
      clear_done_q <= clear_done_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_hit    = rsp_hit_q;
  assign rsp_value  = rsp_value_q;
  assign clear_done = clear_done_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_hashmap_port_arbiter.sv
// Directed bench for hashmap_port_arbiter with a behavioural direct-mapped hashmap.
// A second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_hashmap_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       mdl_init;
  logic [1:0] req_valid, req_write;
  logic [7:0] req_key, req_value;
  logic       clear_req;

  logic [1:0] req_ready, rsp_valid;
  logic       rsp_hit, clear_done;
  logic [3:0] rsp_value;
  logic [7:0] hit_count, miss_count;
  logic [3:0] hm_write_key, hm_write_value, hm_read_key, hm_read_value;
  logic       hm_write_request, hm_read_response, hm_clear_cache;

  logic [1:0] s_req_ready, s_rsp_valid;
  logic       s_rsp_hit, s_clear_done;
  logic [3:0] s_rsp_value;
  logic [1:0] s_hit_count, s_miss_count;
  logic [3:0] s_hm_write_key, s_hm_write_value, s_hm_read_key;
  logic       s_hm_write_request, s_hm_clear_cache;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hashmap_port_arbiter #(.NUM_REQ(2), .KEY_WIDTH(4), .VALUE_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_key(req_key), .req_value(req_value), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_value(rsp_value),
    .clear_req(clear_req), .clear_done(clear_done),
    .hit_count(hit_count), .miss_count(miss_count),
    .hm_write_key(hm_write_key), .hm_write_value(hm_write_value),
    .hm_write_request(hm_write_request), .hm_read_key(hm_read_key),
    .hm_read_value(hm_read_value), .hm_read_response(hm_read_response),
    .hm_clear_cache(hm_clear_cache)
  );

  hashmap_port_arbiter #(.NUM_REQ(2), .KEY_WIDTH(4), .VALUE_WIDTH(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_key(req_key), .req_value(req_value), .req_ready(s_req_ready),
    .rsp_valid(s_rsp_valid), .rsp_hit(s_rsp_hit), .rsp_value(s_rsp_value),
    .clear_req(clear_req), .clear_done(s_clear_done),
    .hit_count(s_hit_count), .miss_count(s_miss_count),
    .hm_write_key(s_hm_write_key), .hm_write_value(s_hm_write_value),
    .hm_write_request(s_hm_write_request), .hm_read_key(s_hm_read_key),
    .hm_read_value(hm_read_value), .hm_read_response(hm_read_response),
    .hm_clear_cache(s_hm_clear_cache)
  );

  // Hashmap model: one slot per key, write and clear at the edge, combinational read.
  logic [15:0] slot_vld;
  logic [3:0]  slot_val [16];

  always @(posedge clk) begin
    if (hm_clear_cache || mdl_init) begin
      slot_vld <= '0;
    end else if (hm_write_request) begin
      slot_vld[hm_write_key] <= 1'b1;
      slot_val[hm_write_key] <= hm_write_value;
    end
  end

  assign hm_read_response = slot_vld[hm_read_key];
  assign hm_read_value    = slot_val[hm_read_key];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_gnt;

  initial begin
    // Reset with every input active: nothing may be granted, written or cleared.
    rst = 1'b1; mdl_init = 1'b1; clear_req = 1'b1;
    req_valid = 2'b11; req_write = 2'b11; req_key = 8'h21; req_value = 8'h43;
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_wreq", hm_write_request, 1'b0);
    check("rst_clear", hm_clear_cache, 1'b0);
    tick; tick;
    mdl_init = 1'b0;
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_hits", hit_count, 8'd0);
    check("rst_misses", miss_count, 8'd0);
    check("rst_clear_done", clear_done, 1'b0);
    check("rst_held_key", hm_write_key, 4'd0);
    rst = 1'b0; clear_req = 1'b0; req_valid = 2'b00;

    // 1: insert key 3 = 9, then look it up.
    req_valid = 2'b01; req_write = 2'b01; req_key = 8'h03; req_value = 8'h09;
    #1;
    check("ins_ready", req_ready, 2'b01);
    check("ins_wreq", hm_write_request, 1'b1);
    check("ins_wkey", hm_write_key, 4'd3);
    check("ins_wval", hm_write_value, 4'd9);
    tick;
    req_write = 2'b00;
    #1;
    check("lkp_ready", req_ready, 2'b01);
    check("lkp_rkey", hm_read_key, 4'd3);
    check("lkp_wreq_idle", hm_write_request, 1'b0);
    check("lkp_wkey_held", hm_write_key, 4'd3);
    tick;
    req_valid = 2'b00;
    check("hit_rsp_valid", rsp_valid, 2'b01);
    check("hit_flag", rsp_hit, 1'b1);
    check("hit_value", rsp_value, 4'd9);
    check("hit_count1", hit_count, 8'd1);
    check("miss_count0", miss_count, 8'd0);

    // 2: requester 1 looks up key 5, which was never inserted.
    req_valid = 2'b10; req_write = 2'b00; req_key = 8'h50;
    #1;
    check("miss_ready", req_ready, 2'b10);
    check("miss_rkey", hm_read_key, 4'd5);
    tick;
    check("miss_rsp_valid", rsp_valid, 2'b10);
    check("miss_flag", rsp_hit, 1'b0);
    check("miss_count1", miss_count, 8'd1);
    check("miss_hits_same", hit_count, 8'd1);

    // 3: both requesters continuously valid from reset alternate 0,1,0,1,0,1.
    rst = 1'b1; req_valid = 2'b00;
    tick;
    rst = 1'b0; req_valid = 2'b11; req_write = 2'b00; req_key = 8'h73;
    exp_gnt = 2'b01;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready", req_ready, exp_gnt);
      tick;
      check("rr_rsp_valid", rsp_valid, exp_gnt);
      exp_gnt = {exp_gnt[0], exp_gnt[1]};
    end
    check("rr_hits", hit_count, 8'd3);
    check("rr_misses", miss_count, 8'd3);

    // 4: clear held two cycles, with an insert pending; then key 3 must miss.
    req_valid = 2'b11; req_write = 2'b01; req_value = 8'h05; clear_req = 1'b1;
    #1;
    check("clr_ready", req_ready, 2'b00);
    check("clr_cache", hm_clear_cache, 1'b1);
    check("clr_wreq", hm_write_request, 1'b0);
    tick;
    check("clr_done1", clear_done, 1'b1);
    check("clr_no_rsp", rsp_valid, 2'b00);
    tick;
    check("clr_done2", clear_done, 1'b1);
    clear_req = 1'b0; req_valid = 2'b01; req_write = 2'b00;
    #1;
    check("post_clr_ready", req_ready, 2'b01);
    tick;
    check("clr_done_end", clear_done, 1'b0);
    check("post_clr_valid", rsp_valid, 2'b01);
    check("post_clr_hit", rsp_hit, 1'b0);
    check("post_clr_miss", miss_count, 8'd4);
    check("post_clr_hits", hit_count, 8'd3);

    // 5: five misses saturate a 2-bit counter at 3.
    rst = 1'b1; req_valid = 2'b00;
    tick;
    rst = 1'b0; req_valid = 2'b01; req_write = 2'b00; req_key = 8'h05;
    repeat (5) tick;
    check("sat_wide_miss", miss_count, 8'd5);
    check("sat_miss", s_miss_count, 2'd3);
    check("sat_hits", s_hit_count, 2'd0);

    // 6: reset on a would-be lookup cycle; pointer returns to requester 0.
    req_valid = 2'b11; req_write = 2'b00; req_key = 8'h33; rst = 1'b1;
    #1;
    check("rst_mid_ready", req_ready, 2'b00);
    tick;
    check("rst_mid_no_rsp", rsp_valid, 2'b00);
    rst = 1'b0;
    #1;
    check("rst_ptr_ready", req_ready, 2'b01);
    tick;
    check("rst_ptr_rsp", rsp_valid, 2'b01);
    req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
